// File: rtl/onehot_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_arbiter
//   N-way arbiter with a registered one-hot grant that is held until the
//   owner releases it. Fixed priority picks the highest requesting index.
//   Round-robin mode searches downward from an internal pointer, with wrap.
//   After a round-robin grant at index k is released, the pointer moves
//   to k-1.
//
// Parameters
//   N      number of requesters (2..32)
//   IDX_W  width of gnt_idx, ceil(log2(N))
//   RR_EN  1: round-robin selectable through mode; 0: fixed priority only
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        request vector, bit i = requester i
//   mode       0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   rel        grant holder releases the grant (ignored while idle)
//   gnt        registered one-hot grant
//   gnt_idx    binary index of the granted requester, 0 when no grant
//   gnt_valid  high while a grant is held
// ---------------------------------------------------------------------------
module onehot_arbiter #(
  parameter int N     = 32,
  parameter int IDX_W = 5,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  // Mode latched when the current grant was issued; it decides whether the
  // release of that grant advances the pointer.
  logic             rr_q, rr_d;
  logic [N-1:0]     gnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;

  logic             use_rr;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  assign use_rr = RR_EN && mode;

  // Winner search. Candidate order is computed modulo N so that indices at
  // or above N are never visited, even when N is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < N; off++) begin
      if (use_rr) begin
        cand = int'(ptr_q) - off;
        if (cand < 0) cand = cand + N;
      end else begin
        cand = N - 1 - off;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rr_d    = rr_q;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (win_found) begin
          state_d        = GRANT;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          valid_d        = 1'b1;
          rr_d           = use_rr;
        end
      end
      GRANT: begin
        // Release wins over any new requests; they are arbitrated in the
        // following idle cycle with the updated pointer.
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          if (rr_q) begin
            ptr_d = (gnt_idx == '0) ? PTR_TOP : gnt_idx - IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_TOP;
      rr_q      <= 1'b0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rr_q      <= rr_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_arbiter
//   Bench for onehot_arbiter with N=8 and RR_EN=1. It runs directed
//   scenarios against fixed expected values, followed by a long random run
//   checked against a transaction-level model. The model tracks the owner
//   index, the round-robin pointer and the mode under which the owner won.
// ---------------------------------------------------------------------------
module tb_onehot_arbiter;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             mode;
  logic             rel;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  int tests;
  int fails;

  // Reference model state
  int m_owner;   // -1 when nobody holds the grant
  int m_ptr;
  bit m_rr;

  onehot_arbiter #(.N(N), .IDX_W(IDX_W), .RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(logic [N-1:0] r, bit m, int p);
    if (m) begin
      for (int off = 0; off < N; off++) begin
        int i;
        i = (p - off + N) % N;
        if (r[i]) return i;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // Apply one cycle of inputs, advance the model, then move to 1 time unit
  // past the active edge so outputs are stable for checking.
  task automatic drive_cycle(input logic [N-1:0] r, input logic m,
                             input logic rl, input logic rs);
    req  = r;
    mode = m;
    rel  = rl;
    rst  = rs;
    if (rs) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_rr    = 1'b0;
    end else if (m_owner < 0) begin
      int k;
      k = model_pick(r, m, m_ptr);
      if (k >= 0) begin
        m_owner = k;
        m_rr    = m;
      end
    end else if (rl) begin
      if (m_rr) m_ptr = (m_owner + N - 1) % N;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(8'hFF, 1'b1, 1'b0, 1'b1);
    tests++;
    if (gnt !== 8'h00) begin
      fails++;
      $display("FAIL reset_gnt: got %b expected %b", gnt, 8'h00);
    end
    tests++;
    if (gnt_idx !== 3'd0) begin
      fails++;
      $display("FAIL reset_idx: got %0d expected 0", gnt_idx);
    end
    tests++;
    if (gnt_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", gnt_valid);
    end
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b0);
    tests++;
    if (gnt_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_noreq_valid: got %b expected 0", gnt_valid);
    end
  endtask

  task automatic test_fixed();
    drive_cycle(8'b0010_0110, 1'b0, 1'b0, 1'b0);
    tests++;
    if (gnt !== 8'b0010_0000 || gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
      fails++;
      $display("FAIL fixed_grant: got gnt=%b idx=%0d v=%b expected gnt=00100000 idx=5 v=1",
               gnt, gnt_idx, gnt_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(8'h00, c[0], 1'b0, 1'b0);
      tests++;
      if (gnt !== 8'b0010_0000 || gnt_idx !== 3'd5) begin
        fails++;
        $display("FAIL fixed_hold%0d: got gnt=%b idx=%0d expected gnt=00100000 idx=5",
                 c, gnt, gnt_idx);
      end
    end
    drive_cycle(8'h00, 1'b0, 1'b1, 1'b0);
    tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      fails++;
      $display("FAIL fixed_release: got gnt=%b idx=%0d v=%b expected all zero",
               gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_rr_wrap();
    for (int g = 0; g < 9; g++) begin
      int exp_k;
      logic [N-1:0] exp_g;
      exp_k = (7 - g + 2 * N) % N;
      exp_g = '0;
      exp_g[exp_k] = 1'b1;
      drive_cycle(8'hFF, 1'b1, 1'b0, 1'b0);
      tests++;
      if (gnt_idx !== 3'(exp_k) || gnt !== exp_g) begin
        fails++;
        $display("FAIL rr_wrap%0d: got gnt=%b idx=%0d expected gnt=%b idx=%0d",
                 g, gnt, gnt_idx, exp_g, exp_k);
      end
      drive_cycle(8'hFF, 1'b1, 1'b1, 1'b0);
      tests++;
      if (gnt_valid !== 1'b0) begin
        fails++;
        $display("FAIL rr_wrap_rel%0d: got valid=%b expected 0", g, gnt_valid);
      end
    end
  endtask

  task automatic test_rr_skip();
    drive_cycle(8'b1000_0001, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd0 || gnt !== 8'b0000_0001) begin
      fails++;
      $display("FAIL rr_skip_low: got gnt=%b idx=%0d expected idx=0", gnt, gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
    drive_cycle(8'b1000_0001, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd7 || gnt !== 8'b1000_0000) begin
      fails++;
      $display("FAIL rr_skip_wrap: got gnt=%b idx=%0d expected idx=7", gnt, gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_cycle(8'b0000_1000, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd3) begin
      fails++;
      $display("FAIL b2b_first: got idx=%0d expected 3", gnt_idx);
    end
    drive_cycle(8'b0000_1100, 1'b1, 1'b1, 1'b0);
    tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_release: got gnt=%b v=%b expected 0", gnt, gnt_valid);
    end
    drive_cycle(8'b0000_1100, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd2 || gnt !== 8'b0000_0100) begin
      fails++;
      $display("FAIL b2b_second: got gnt=%b idx=%0d expected idx=2", gnt, gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_grant();
    drive_cycle(8'b0100_0000, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt !== 8'b0100_0000) begin
      fails++;
      $display("FAIL midrst_pre: got gnt=%b expected 01000000", gnt);
    end
    drive_cycle(8'b0100_0000, 1'b1, 1'b0, 1'b1);
    tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_drop: got gnt=%b v=%b expected 0", gnt, gnt_valid);
    end
    drive_cycle(8'hFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_after: got idx=%0d v=%b expected idx=7 v=1", gnt_idx, gnt_valid);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_release_idle();
    for (int c = 0; c < 2; c++) begin
      drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
      tests++;
      if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
        fails++;
        $display("FAIL idle_release%0d: got gnt=%b v=%b expected 0", c, gnt, gnt_valid);
      end
    end
    drive_cycle(8'hFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd6) begin
      fails++;
      $display("FAIL idle_release_ptr: got idx=%0d expected 6", gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_mode_in_grant();
    drive_cycle(8'b0000_0101, 1'b0, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd2) begin
      fails++;
      $display("FAIL mode_grant: got idx=%0d expected 2", gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt !== 8'b0000_0100) begin
      fails++;
      $display("FAIL mode_hold: got gnt=%b expected 00000100", gnt);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
    drive_cycle(8'hFF, 1'b1, 1'b0, 1'b0);
    tests++;
    if (gnt_idx !== 3'd5) begin
      fails++;
      $display("FAIL mode_ptr_kept: got idx=%0d expected 5", gnt_idx);
    end
    drive_cycle(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] prev_gnt;
    logic         prev_hold;
    logic [N-1:0] exp_g;
    prev_gnt  = '0;
    prev_hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] r;
      logic         m, rl, rs;
      if ($urandom_range(0, 3) == 0) r = '0;
      else if ($urandom_range(0, 1) == 0) r = N'(1) << $urandom_range(0, N - 1);
      else r = N'($urandom);
      m  = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 9) < 3);
      rs = ($urandom_range(0, 99) == 0);
      drive_cycle(r, m, rl, rs);
      exp_g = model_gnt();
      tests++;
      if (gnt !== exp_g || gnt_valid !== (m_owner >= 0) ||
          gnt_idx !== ((m_owner >= 0) ? 3'(m_owner) : 3'd0)) begin
        fails++;
        $display("FAIL rand_model@%0d: got gnt=%b idx=%0d v=%b expected gnt=%b owner=%0d",
                 c, gnt, gnt_idx, gnt_valid, exp_g, m_owner);
      end
      tests++;
      if (!$onehot0(gnt) || (gnt_valid !== (gnt != '0)) ||
          (gnt_valid && gnt[gnt_idx] !== 1'b1) || (!gnt_valid && gnt_idx !== 3'd0)) begin
        fails++;
        $display("FAIL rand_invariant@%0d: got gnt=%b idx=%0d v=%b expected consistent one-hot",
                 c, gnt, gnt_idx, gnt_valid);
      end
      if (prev_hold) begin
        tests++;
        if (gnt !== prev_gnt) begin
          fails++;
          $display("FAIL rand_stable@%0d: got gnt=%b expected %b", c, gnt, prev_gnt);
        end
      end
      // The grant must stay unchanged through the next edge unless that
      // edge carries a release or a reset.
      prev_gnt  = gnt;
      prev_hold = gnt_valid;
      if (prev_hold) begin
        r  = req;
        m  = mode;
        rl = 1'($urandom_range(0, 9) < 3);
        rs = 1'($urandom_range(0, 99) == 0);
        prev_hold = !rl && !rs;
        drive_cycle(N'($urandom), 1'($urandom_range(0, 1)), rl, rs);
        exp_g = model_gnt();
        tests++;
        if (gnt !== exp_g) begin
          fails++;
          $display("FAIL rand_grant@%0d: got gnt=%b expected %b", c, gnt, exp_g);
        end
        if (prev_hold) begin
          tests++;
          if (gnt !== prev_gnt) begin
            fails++;
            $display("FAIL rand_hold@%0d: got gnt=%b expected %b", c, gnt, prev_gnt);
          end
        end
        prev_gnt  = gnt;
        prev_hold = 1'b0;
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    m_owner = -1;
    m_ptr   = N - 1;
    m_rr    = 1'b0;
    rst     = 1'b1;
    req     = '0;
    mode    = 1'b0;
    rel     = 1'b0;
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_rr_skip();
    test_back_to_back();
    test_reset_mid_grant();
    test_release_idle();
    test_mode_in_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
